// File: rtl/pad_out_serializer.sv
// Registered LSB-first serializer driving LIFCL PADDO/PADDT with turnaround before and after each frame.
// Optional feature: define PAD_SER_PARITY_EN to append an even-parity bit to every word.
module pad_out_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   TURNAROUND = 2,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             paddo,
   output logic             paddt,
   output logic             busy
);

`ifdef PAD_SER_PARITY_EN
   localparam int SREG_W = WIDTH + 1;
`else
   localparam int SREG_W = WIDTH;
`endif
   localparam logic [5:0] LAST_BIT  = 6'(SREG_W - 1);
   localparam logic [3:0] LAST_TURN = 4'(TURNAROUND - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENABLE  = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [3:0]        turn_cnt_r, turn_cnt_s;
   logic [5:0]        bit_cnt_r, bit_cnt_s;
   logic [SREG_W-1:0] sreg_r, sreg_s;
   logic              in_ready_r, in_ready_s;
   logic              paddo_r, paddo_s;
   logic              paddt_r, paddt_s;
   logic              busy_r, busy_s;
   logic              accept_s;

`ifdef PAD_SER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   function automatic logic [SREG_W-1:0] load_word(input logic [WIDTH-1:0] d);
      return {even_parity(d), d};
   endfunction
`else
   function automatic logic [SREG_W-1:0] load_word(input logic [WIDTH-1:0] d);
      return d;
   endfunction
`endif

   // Accept uses the registered ready so nothing from the inputs reaches the pad combinationally.
   assign accept_s = in_valid & in_ready_r;

   // Next-state, counter, shift-register and next-output decode.
   always_comb begin
      state_s    = state_r;
      turn_cnt_s = turn_cnt_r;
      bit_cnt_s  = bit_cnt_r;
      sreg_s     = sreg_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               sreg_s     = load_word(in_data);
               turn_cnt_s = 4'd0;
               bit_cnt_s  = 6'd0;
               state_s    = ST_ENABLE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ENABLE: begin
            if (turn_cnt_r >= LAST_TURN) begin
               turn_cnt_s = 4'd0;
               bit_cnt_s  = 6'd0;
               state_s    = ST_SHIFT;
            end else begin
               turn_cnt_s = turn_cnt_r + 4'd1;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_r >= LAST_BIT) begin
               bit_cnt_s  = 6'd0;
               turn_cnt_s = 4'd0;
               // A word taken on the last-bit cycle continues with no gap.
               if (accept_s) begin
                  sreg_s  = load_word(in_data);
                  state_s = ST_SHIFT;
               end else begin
                  state_s = ST_RELEASE;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 6'd1;
               sreg_s    = sreg_r >> 1;
            end
         end
         ST_RELEASE: begin
            if (turn_cnt_r >= LAST_TURN) begin
               turn_cnt_s = 4'd0;
               state_s    = ST_IDLE;
            end else begin
               turn_cnt_s = turn_cnt_r + 4'd1;
            end
         end
         default: begin
            turn_cnt_s = 4'd0;
            bit_cnt_s  = 6'd0;
            state_s    = ST_IDLE;
         end
      endcase

      paddt_s    = (state_s == ST_IDLE);
      busy_s     = (state_s != ST_IDLE);
      in_ready_s = (state_s == ST_IDLE) ||
                   ((state_s == ST_SHIFT) && (bit_cnt_s == LAST_BIT));
      paddo_s    = (state_s == ST_SHIFT) ? sreg_s[0] : IDLE_LEVEL;
   end

   // State, counters and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         turn_cnt_r <= 4'd0;
         bit_cnt_r  <= 6'd0;
         sreg_r     <= '0;
         in_ready_r <= 1'b0;
         paddo_r    <= IDLE_LEVEL;
         paddt_r    <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         turn_cnt_r <= turn_cnt_s;
         bit_cnt_r  <= bit_cnt_s;
         sreg_r     <= sreg_s;
         in_ready_r <= in_ready_s;
         paddo_r    <= paddo_s;
         paddt_r    <= paddt_s;
         busy_r     <= busy_s;
      end
   end

   assign in_ready = in_ready_r;
   assign paddo    = paddo_r;
   assign paddt    = paddt_r;
   assign busy     = busy_r;

endmodule

// File: doc/pad_out_serializer.md
# pad_out_serializer

Registered output stage that drives the data and tristate inputs of a LIFCL output or bidirectional pad primitive (PADDO/PADDT of OB/BB). It accepts parallel words over a valid/ready handshake and shifts them out LSB-first, one bit per clock. The pad is enabled for a fixed turnaround window before data and after data, and released to high-Z when idle. It sits directly upstream of the pad buffer in IO-mode fuzzer designs and in user logic that needs a clean, glitch-free pad drive sequence.

## Interface

- WIDTH, 8: data word width in bits; legal range 2..32.
- TURNAROUND, 2: cycles the pad is driven at IDLE_LEVEL before the first bit and after the last bit; legal range 1..15.
- IDLE_LEVEL, 1'b1: level driven on paddo whenever no data bit is being sent.

- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to send; sampled on accept.
- in_valid  input  1  word present.
- in_ready  output  1  block can accept; accept = in_valid & in_ready.
- paddo  output  1  pad data, to primitive PADDO.
- paddt  output  1  pad tristate, to primitive PADDT; 1 = high-Z, 0 = driven.
- busy  output  1  high in every state except IDLE.

## Operation

- All outputs are registered; there is no combinational path from inputs to paddo or paddt.
- Reset values: paddt=1, paddo=IDLE_LEVEL, in_ready=0 while rst is high, busy=0, state=IDLE, counters=0.
- States and transitions:
  - IDLE: paddt=1, in_ready=1. An accept loads the shift register and moves to ENABLE.
  - ENABLE: paddt=0, paddo=IDLE_LEVEL for TURNAROUND cycles, then moves to SHIFT.
  - SHIFT: paddo=sreg[0] and the register shifts right each cycle. A bit counter runs 0..WIDTH-1, or 0..WIDTH with parity enabled. After the last bit:
    - if a word was accepted on the last-bit cycle, go to SHIFT with the new word, with no gap and no turnaround;
    - otherwise go to RELEASE.
  - RELEASE: paddt=0, paddo=IDLE_LEVEL for TURNAROUND cycles, then go to IDLE with paddt=1.
- in_ready rules:
  - 1 in IDLE and on the last-bit cycle of SHIFT;
  - 0 in every other cycle, including the reset cycle.
- Counters saturate and reload; they never wrap. The turnaround counter is 4 bits and the bit counter is 6 bits.
- Reset asserted mid-operation: the next cycle shows reset values. A partially sent word is discarded and the pad goes high-Z immediately.
- in_data is ignored whenever no accept occurs.

## Timing

- An accept sampled at edge N gives paddt=0 from cycle N+1. The first data bit appears at cycle N+1+TURNAROUND.
- Each bit is held exactly one cycle.
- Last bit k = WIDTH-1 (or WIDTH with parity) appears at cycle N+1+TURNAROUND+k.
- With no back-to-back word, paddt returns to 1 at cycle N+1+2·TURNAROUND+k+1.
- Back-to-back: the first bit of the next word directly follows the last bit of the previous word.
- busy is high for the same cycles that paddt is 0.

## Configuration

- PAD_SER_PARITY_EN defined:
  - one extra bit follows the data bits in SHIFT, carrying the even parity of the word (XOR of all in_data bits);
  - bit counter terminal value is WIDTH.
- PAD_SER_PARITY_EN undefined: no parity bit is sent, and the frame is WIDTH data bits only.

## Test plan

- Single word, parity off, WIDTH=8, TURNAROUND=2, IDLE_LEVEL=1: accept 0xA5 at edge 0 ->
  - paddt=0 in cycles 1–12;
  - paddo=1 in cycles 1–2;
  - paddo bits 1,0,1,0,0,1,0,1 in cycles 3–10;
  - paddo=1 in cycles 11–12;
  - paddt=1 from cycle 13; in_ready=1 from cycle 13.
- Back-to-back: 0xA5 at edge 0, 0x3C held valid -> 0x3C is accepted at the cycle-10 edge; bits 0,0,1,1,1,1,0,0 appear in cycles 11–18; release in cycles 19–20; paddt=1 at cycle 21.
- Backpressure: in_valid held high with in_ready=0 during ENABLE and RELEASE -> no accept and no data change.
- Reset mid-SHIFT: rst=1 at cycle 6 -> at cycle 7 paddt=1, paddo=1, busy=0; after rst drops, a new word sends normally.
- Parity, PAD_SER_PARITY_EN defined: 0xA5 gives parity bit 0 in cycle 11 and paddt=1 at cycle 14; 0x07 gives parity bit 1.
- IDLE_LEVEL=0, TURNAROUND=1: accept 0xFF -> paddo=0 in cycle 1, paddo=1 in cycles 2–9, paddo=0 in cycle 10, paddt=1 at cycle 11.
